// File: rtl/pe_pkg.sv
// Shared definitions for the matrix-PE feeder: default widths, PE control
// bit positions and the feeder FSM state encoding.
package pe_pkg;

  // Default datapath and addressing widths
  localparam int DATA_W = 512;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;

  // Bit positions inside the 2-bit PE ctl bus
  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;

  // Feeder state encodings
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    RUN   = ST_RUN_ENC,
    DRAIN = ST_DRAIN_ENC,
    DONE  = ST_DONE_ENC
  } feeder_state_e;

  // A job with zero chunks or zero rows has nothing to stream
  function automatic logic cfg_empty(input logic [LEN_W-1:0] len,
                                     input logic [LEN_W-1:0] num);
    return (len == '0) || (num == '0);
  endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of job-control, buffer-read and PE-facing signals of the feeder.
// The master modport is the feeder itself; slave is its environment.
interface pe_feeder_if
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ADDR_W = pe_pkg::ADDR_W,
  parameter int LEN_W  = pe_pkg::LEN_W
) ();

  // Job control
  logic              start;
  logic [ADDR_W-1:0] cfg_n_base;
  logic [ADDR_W-1:0] cfg_w_base;
  logic [LEN_W-1:0]  cfg_len;
  logic [LEN_W-1:0]  cfg_num;
  logic              stall;
  logic              busy;
  logic              done;

  // Neuron and weight buffer read ports (1-cycle read latency)
  logic              nbuf_rd_en;
  logic [ADDR_W-1:0] nbuf_addr;
  logic [DATA_W-1:0] nbuf_rdata;
  logic              wbuf_rd_en;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_rdata;

  // PE stream
  logic [DATA_W-1:0] neuron;
  logic [DATA_W-1:0] weight;
  logic [1:0]        ctl;
  logic              pe_vld;

  // Performance counters
  logic [31:0]       perf_busy;
  logic [31:0]       perf_stall;

  modport master (
    input  start, cfg_n_base, cfg_w_base, cfg_len, cfg_num, stall,
    input  nbuf_rdata, wbuf_rdata,
    output busy, done,
    output nbuf_rd_en, nbuf_addr, wbuf_rd_en, wbuf_addr,
    output neuron, weight, ctl, pe_vld,
    output perf_busy, perf_stall
  );

  modport slave (
    output start, cfg_n_base, cfg_w_base, cfg_len, cfg_num, stall,
    output nbuf_rdata, wbuf_rdata,
    input  busy, done,
    input  nbuf_rd_en, nbuf_addr, wbuf_rd_en, wbuf_addr,
    input  neuron, weight, ctl, pe_vld,
    input  perf_busy, perf_stall
  );

endinterface

// File: rtl/pe_feeder_agu.sv
// Address generator for the PE feeder. Holds the chunk index k and row
// index r, a neuron pointer that rewinds to the base at every row end and a
// weight pointer that simply runs forward (weight rows are contiguous), so
// no multiplier is needed. Pointers wrap modulo 2^ADDR_W.
module pe_feeder_agu
  import pe_pkg::*;
#(
  parameter int ADDR_W = pe_pkg::ADDR_W,
  parameter int LEN_W  = pe_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] n_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [LEN_W-1:0]  num_i,
  output logic [ADDR_W-1:0] n_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic              first_o,
  output logic              last_o,
  output logic              end_o
);

  logic [ADDR_W-1:0] n_base_q, n_base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  num_q, num_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  r_q, r_d;
  logic [ADDR_W-1:0] n_ptr_q, n_ptr_d;
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic              last_chunk;

  assign last_chunk = (k_q == (len_q - LEN_W'(1)));

  assign n_addr_o = n_ptr_q;
  assign w_addr_o = w_ptr_q;
  assign first_o  = (k_q == '0);
  assign last_o   = last_chunk;
  assign end_o    = last_chunk && (r_q == (num_q - LEN_W'(1)));

  // Latch job config on load, otherwise step k/r and both pointers per issue
  always_comb begin
    n_base_d = n_base_q;
    len_d    = len_q;
    num_d    = num_q;
    k_d      = k_q;
    r_d      = r_q;
    n_ptr_d  = n_ptr_q;
    w_ptr_d  = w_ptr_q;
    if (load_i) begin
      n_base_d = n_base_i;
      len_d    = len_i;
      num_d    = num_i;
      k_d      = '0;
      r_d      = '0;
      n_ptr_d  = n_base_i;
      w_ptr_d  = w_base_i;
    end else if (adv_i) begin
      w_ptr_d = w_ptr_q + ADDR_W'(1);
      if (last_chunk) begin
        k_d     = '0;
        r_d     = r_q + LEN_W'(1);
        n_ptr_d = n_base_q;
      end else begin
        k_d     = k_q + LEN_W'(1);
        n_ptr_d = n_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Counter and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n_base_q <= '0;
      len_q    <= '0;
      num_q    <= '0;
      k_q      <= '0;
      r_q      <= '0;
      n_ptr_q  <= '0;
      w_ptr_q  <= '0;
    end else begin
      n_base_q <= n_base_d;
      len_q    <= len_d;
      num_q    <= num_d;
      k_q      <= k_d;
      r_q      <= r_d;
      n_ptr_q  <= n_ptr_d;
      w_ptr_q  <= w_ptr_d;
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Upstream sequencer for the matrix PE. Streams cfg_num dot products of
// cfg_len chunk pairs from the neuron/weight buffers into the PE at one
// chunk per cycle, tagging first/last chunks on ctl.
// Optional feature: define PE_FEEDER_PERF_EN to build the busy/stall
// performance counters; otherwise perf_busy/perf_stall read as zero.
module pe_feeder
  import pe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pe_feeder_if.master  bus
);

  feeder_state_e state_q, state_d;

  logic       accept;
  logic       load;
  logic       rd_en;
  logic       busy;
  logic       done;
  logic       agu_first;
  logic       agu_last;
  logic       agu_end;
  logic       pe_vld_q, pe_vld_d;
  logic [1:0] ctl_q, ctl_d;

  assign accept = (state_q == IDLE) && bus.start;
  assign load   = accept && !cfg_empty(bus.cfg_len, bus.cfg_num);

  pe_feeder_agu #(
    .ADDR_W (pe_pkg::ADDR_W),
    .LEN_W  (pe_pkg::LEN_W)
  ) u_agu (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .adv_i    (rd_en),
    .n_base_i (bus.cfg_n_base),
    .w_base_i (bus.cfg_w_base),
    .len_i    (bus.cfg_len),
    .num_i    (bus.cfg_num),
    .n_addr_o (bus.nbuf_addr),
    .w_addr_o (bus.wbuf_addr),
    .first_o  (agu_first),
    .last_o   (agu_last),
    .end_o    (agu_end)
  );

  // Next state plus the state-decoded outputs (busy, done, read enable)
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = cfg_empty(bus.cfg_len, bus.cfg_num) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = !bus.stall;
        if (!bus.stall && agu_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flags travel one stage behind the read so they line up with returning data
  always_comb begin
    pe_vld_d           = rd_en;
    ctl_d              = 2'b00;
    ctl_d[CTL_FIRST]   = rd_en && agu_first;
    ctl_d[CTL_LAST]    = rd_en && agu_last;
  end

  // Flag pipe register; cleared on reset so an in-flight read never shows up
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_vld_q <= 1'b0;
      ctl_q    <= 2'b00;
    end else begin
      pe_vld_q <= pe_vld_d;
      ctl_q    <= ctl_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.nbuf_rd_en = rd_en;
  assign bus.wbuf_rd_en = rd_en;
  assign bus.neuron     = bus.nbuf_rdata;
  assign bus.weight     = bus.wbuf_rdata;
  assign bus.pe_vld     = pe_vld_q;
  assign bus.ctl        = ctl_q;

`ifdef PE_FEEDER_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  // Saturating busy / stalled-busy cycle counters, restarted by each accepted job
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (busy && bus.stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign bus.perf_busy  = perf_busy_q;
  assign bus.perf_stall = perf_stall_q;
`else
  assign bus.perf_busy  = 32'h0;
  assign bus.perf_stall = 32'h0;
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder. Buffers are modelled as 1-cycle
// memories whose contents are a hash of the address, so data checks also
// prove the address order. A job-level reference model expands each accepted
// job into its list of chunks and predicts every cycle's outputs.
module tb_pe_feeder;
  import pe_pkg::*;

  localparam int DW  = pe_pkg::DATA_W;
  localparam int AW  = pe_pkg::ADDR_W;
  localparam int LW  = pe_pkg::LEN_W;
  localparam int DEP = 1 << AW;

  typedef struct {
    int         n;
    int         w;
    logic [1:0] ctl;
  } chunk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pe_feeder_if bus ();

  pe_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmpCount = 0;
  int errCount = 0;

  // Reference model state
  chunk_t pend[$];
  chunk_t expChunk;
  bit     mActive   = 1'b0;
  int     mPost     = 0;
  bit     expVld    = 1'b0;
  bit     expDone   = 1'b0;
  bit     expBusy   = 1'b0;
  longint mPerfBusy  = 0;
  longint mPerfStall = 0;
  bit     cmpEn     = 1'b0;

  // Observation logs for directed tests
  int     issN[$];
  int     issW[$];
  int     issCyc[$];
  int     vldCtl[$];
  int     doneCount = 0;
  int     tStart = 0;

  int t1Ctl[4]  = '{1, 0, 0, 2};
  int t3Iss[3]  = '{1, 4, 5};
  int t6Wadr[4] = '{'h3FE, 'h3FF, 0, 1};

  function automatic logic [DW-1:0] nData(input logic [AW-1:0] a);
    logic [31:0] w;
    w = ({22'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    return {(DW/32){w}};
  endfunction

  function automatic logic [DW-1:0] wData(input logic [AW-1:0] a);
    logic [31:0] w;
    w = ({22'h0, a} * 32'h85EB_CA6B) ^ 32'hC3C3_7E02;
    return {(DW/32){w}};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Buffer memories: data appears one cycle after the read enable
  always @(posedge clk) begin
    if (bus.nbuf_rd_en) bus.nbuf_rdata <= nData(bus.nbuf_addr);
    if (bus.wbuf_rd_en) bus.wbuf_rdata <= wData(bus.wbuf_addr);
  end

  // Reference model: decide what the coming cycle must look like
  always @(posedge clk) begin
    bit wasBusy;
    int len, num, nb, wb;
    wasBusy = expBusy;
    if (rst) begin
      pend.delete();
      mActive = 0; mPost = 0;
      expVld = 0; expDone = 0; expBusy = 0;
      mPerfBusy = 0; mPerfStall = 0;
    end else begin
      if (!mActive && bus.start) begin
        mPerfBusy = 0; mPerfStall = 0;
      end else if (wasBusy) begin
        mPerfBusy++;
        if (bus.stall) mPerfStall++;
      end
      expVld = 0; expDone = 0;
      if (!mActive) begin
        if (bus.start) begin
          len = int'(bus.cfg_len); num = int'(bus.cfg_num);
          nb = int'(bus.cfg_n_base); wb = int'(bus.cfg_w_base);
          mActive = 1; expBusy = 1; mPost = 0;
          pend.delete();
          for (int r = 0; r < num; r++)
            for (int k = 0; k < len; k++)
              pend.push_back('{n: (nb + k) % DEP, w: (wb + r * len + k) % DEP,
                               ctl: {k == len - 1, k == 0}});
          if (pend.size() == 0) expDone = 1;
        end
      end else if (pend.size() > 0) begin
        if (!bus.stall) begin
          expVld = 1;
          expChunk = pend.pop_front();
          if (pend.size() == 0) mPost = 2;
        end
      end else if (mPost == 2) begin
        mPost = 0;
        expDone = 1;
      end else begin
        mActive = 0;
        expBusy = 0;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    bit expRd;
    if (cmpEn) begin
      expRd = mActive && (pend.size() > 0) && !bus.stall;
      checkOutput("busy", bus.busy, expBusy);
      checkOutput("done", bus.done, expDone);
      checkOutput("nbuf_rd_en", bus.nbuf_rd_en, expRd);
      checkOutput("wbuf_rd_en", bus.wbuf_rd_en, expRd);
      if (expRd) begin
        checkOutput("nbuf_addr", bus.nbuf_addr, pend[0].n);
        checkOutput("wbuf_addr", bus.wbuf_addr, pend[0].w);
      end
      checkOutput("pe_vld", bus.pe_vld, expVld);
      checkOutput("ctl", bus.ctl, expVld ? expChunk.ctl : 2'b00);
      if (expVld) begin
        checkOutput("neuron", bus.neuron, nData(AW'(expChunk.n)));
        checkOutput("weight", bus.weight, wData(AW'(expChunk.w)));
      end
`ifdef PE_FEEDER_PERF_EN
      checkOutput("perf_busy", bus.perf_busy, 32'(mPerfBusy));
      checkOutput("perf_stall", bus.perf_stall, 32'(mPerfStall));
`else
      checkOutput("perf_busy", bus.perf_busy, 0);
      checkOutput("perf_stall", bus.perf_stall, 0);
`endif
      if (bus.nbuf_rd_en) begin
        issN.push_back(int'(bus.nbuf_addr));
        issW.push_back(int'(bus.wbuf_addr));
        issCyc.push_back(cyc);
      end
      if (bus.pe_vld) vldCtl.push_back(int'(bus.ctl));
      if (bus.done) doneCount++;
    end
  end

  // One job with optional stall window and optional second start; returns done latency
  task automatic applyStimulus(input int len, input int num, input int nb, input int wb,
                               input int stallAt, input int stallCnt, input int againAt,
                               output int dT);
    tick();
    bus.cfg_len    = LW'(len);
    bus.cfg_num    = LW'(num);
    bus.cfg_n_base = AW'(nb);
    bus.cfg_w_base = AW'(wb);
    bus.start      = 1'b1;
    tStart         = cyc;
    issN.delete(); issW.delete(); issCyc.delete(); vldCtl.delete();
    dT = -1;
    for (int i = 1; i <= 60 && dT < 0; i++) begin
      tick();
      bus.start = (i == againAt);
      if (i == againAt) begin
        bus.cfg_len = LW'(2); bus.cfg_num = LW'(3);
        bus.cfg_n_base = AW'('h155); bus.cfg_w_base = AW'('h2AA);
      end
      bus.stall = (i >= stallAt) && (i < stallAt + stallCnt);
      @(negedge clk);
      if (bus.done) dT = cyc - tStart;
    end
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    if (dT < 0) begin
      cmpCount++;
      errCount++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 60 cycles");
    end
  endtask

  initial begin
    int d;
    int dcBefore;
    bus.start = 1'b0; bus.stall = 1'b0;
    bus.cfg_len = '0; bus.cfg_num = '0; bus.cfg_n_base = '0; bus.cfg_w_base = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_rd_en", bus.nbuf_rd_en, 0);
    checkOutput("rst_pe_vld", bus.pe_vld, 0);
    checkOutput("rst_ctl", bus.ctl, 0);
    checkOutput("rst_naddr", bus.nbuf_addr, 0);
    checkOutput("rst_waddr", bus.wbuf_addr, 0);
    checkOutput("rst_perf_busy", bus.perf_busy, 0);
    rst = 1'b0;
    cmpEn = 1'b1;

    $display("[TB] len=4 num=2 bases 0x10/0x40");
    applyStimulus(4, 2, 'h10, 'h40, 0, 0, 0, d);
    checkOutput("t1_done_lat", d, 10);
    checkOutput("t1_issues", issN.size(), 8);
    for (int i = 0; i < 8 && i < issN.size(); i++) begin
      checkOutput("t1_naddr", issN[i], 'h10 + (i % 4));
      checkOutput("t1_waddr", issW[i], 'h40 + i);
    end
    checkOutput("t1_vld_count", vldCtl.size(), 8);
    for (int i = 0; i < 8 && i < vldCtl.size(); i++)
      checkOutput("t1_ctl", vldCtl[i], t1Ctl[i % 4]);

    $display("[TB] len=1 num=3");
    applyStimulus(1, 3, 5, 9, 0, 0, 0, d);
    checkOutput("t2_done_lat", d, 5);
    checkOutput("t2_vld_count", vldCtl.size(), 3);
    for (int i = 0; i < vldCtl.size(); i++)
      checkOutput("t2_ctl", vldCtl[i], 3);

    $display("[TB] len=3 num=1 with 2-cycle stall");
    applyStimulus(3, 1, 0, 0, 2, 2, 0, d);
    checkOutput("t3_done_lat", d, 7);
    checkOutput("t3_issues", issCyc.size(), 3);
    for (int i = 0; i < 3 && i < issCyc.size(); i++)
      checkOutput("t3_issue_cyc", issCyc[i] - tStart, t3Iss[i]);
`ifdef PE_FEEDER_PERF_EN
    checkOutput("t3_perf_stall", bus.perf_stall, 2);
`endif

    $display("[TB] len=0");
    applyStimulus(0, 5, 0, 0, 0, 0, 0, d);
    checkOutput("t4_done_lat", d, 1);
    checkOutput("t4_issues", issN.size(), 0);
    checkOutput("t4_vld_count", vldCtl.size(), 0);

    $display("[TB] start while busy");
    applyStimulus(4, 1, 0, 0, 0, 0, 2, d);
    checkOutput("t5_done_lat", d, 6);
    checkOutput("t5_issues", issN.size(), 4);
    for (int i = 0; i < 4 && i < issN.size(); i++)
      checkOutput("t5_naddr", issN[i], i);

    $display("[TB] weight address wrap");
    applyStimulus(4, 1, 0, 'h3FE, 0, 0, 0, d);
    checkOutput("t6_issues", issW.size(), 4);
    for (int i = 0; i < 4 && i < issW.size(); i++)
      checkOutput("t6_waddr", issW[i], t6Wadr[i]);

    $display("[TB] reset mid-job");
    tick();
    bus.cfg_len = LW'(4); bus.cfg_num = LW'(2);
    bus.cfg_n_base = '0; bus.cfg_w_base = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    dcBefore = doneCount;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t7_pe_vld", bus.pe_vld, 0);
    checkOutput("t7_busy", bus.busy, 0);
    checkOutput("t7_rd_en", bus.nbuf_rd_en, 0);
    repeat (12) tick();
    checkOutput("t7_no_done", doneCount, dcBefore);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.start      = ($urandom_range(7) == 0);
      bus.stall      = ($urandom_range(3) == 0);
      bus.cfg_len    = LW'($urandom_range(5));
      bus.cfg_num    = LW'($urandom_range(4));
      bus.cfg_n_base = AW'($urandom);
      bus.cfg_w_base = AW'($urandom);
      rst            = ($urandom_range(399) == 0);
    end
    tick();
    rst = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
    for (int i = 0; i < 100 && mActive; i++) tick();
    if (mActive) begin
      cmpCount++;
      errCount++;
      $display("[TB] FAIL drain_timeout: got job still active, expected idle within 100 cycles");
    end
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
